fetch_prefetch: RTL and testbench

- Clocked, parametrised instruction fetch unit.
- Assembles INSTR_W-bit instructions from a narrow BUS_W-bit memory port, one beat per memory handshake, little-endian.
- Queues up to DEPTH fetched instructions, each with its PC, for the decode stage via a valid/ready handshake.
- Supports PC redirect with flush; sits between instruction ROM and decode.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 76 +++++++
 rtl/fetch_prefetch.sv | 120 ++++++++++++
 tb/tb_fetch_prefetch.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and size helpers for the instruction prefetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    function automatic int beats_f(input int instr_w, input int bus_w);
        return instr_w / bus_w;
    endfunction

    function automatic int pc_step_f(input int instr_w);
        return instr_w / 8;
    endfunction

    function automatic int beat_bytes_f(input int bus_w);
        return bus_w / 8;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - small FIFO of fetched {instr, pc} entries with a registered head
module fetch_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            // Head holds its last value while empty; a push into an emptying buffer becomes head directly.
            if (count_d != '0) begin
                head_d = (count_q == CNT_W'(pop)) ? push_data : mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign count     = count_q;
    assign head_data = head_q;

endmodule

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - assembles wide instructions from narrow memory beats and queues them for decode
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                INSTR_W  = 32,
    parameter int                BUS_W    = 8,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rstN,
    input  logic               redirectIn,
    input  logic [ADDR_W-1:0]  pcIn,
    output logic               memReqOut,
    output logic [ADDR_W-1:0]  memAddrOut,
    input  logic               memReadyIn,
    input  logic [BUS_W-1:0]   memDataIn,
    output logic               instrValidOut,
    output logic [INSTR_W-1:0] instrOut,
    output logic [ADDR_W-1:0]  instrPcOut,
    input  logic               instrReadyIn
);

    localparam int BEATS      = beats_f(INSTR_W, BUS_W);
    localparam int PC_STEP    = pc_step_f(INSTR_W);
    localparam int BEAT_BYTES = beat_bytes_f(BUS_W);
    localparam int BC_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CNT_W      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    fetch_state_e        state_q, state_d;
    logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [INSTR_W-1:0]  asm_q, asm_d;
    logic                push, pop, flush;
    logic [CNT_W-1:0]    count;
    entry_t              push_entry, head_entry;

    // A redirect cancels any pop so the flush cannot race with decode.
    assign pop = instrValidOut && instrReadyIn && !redirectIn;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        fetch_pc_d = fetch_pc_q;
        asm_d      = asm_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirectIn) begin
            flush      = 1'b1;
            beat_cnt_d = '0;
            fetch_pc_d = pcIn;
            state_d    = FETCH;
        end else begin
            case (state_q)
                START: state_d = FETCH;
                FETCH: begin
                    if (memReadyIn) begin
                        asm_d[beat_cnt_q*BUS_W +: BUS_W] = memDataIn;
                        if (beat_cnt_q == BC_W'(BEATS - 1)) begin
                            push       = 1'b1;
                            beat_cnt_d = '0;
                            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
                            // Stop before starting an instruction that would have no slot to land in.
                            if ((count - CNT_W'(pop) + CNT_W'(1)) == CNT_W'(DEPTH)) begin
                                state_d = FULL;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + BC_W'(1);
                        end
                    end
                end
                FULL: if (pop) state_d = FETCH;
                default: state_d = START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= START;
            beat_cnt_q <= '0;
            fetch_pc_q <= RESET_PC;
            asm_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            fetch_pc_q <= fetch_pc_d;
            asm_q      <= asm_d;
        end
    end

    assign push_entry = '{instr: asm_d, pc: fetch_pc_q};

    fetch_buf #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rstN),
        .flush     (flush),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .count     (count),
        .head_data (head_entry)
    );

    assign memReqOut     = (state_q == FETCH);
    assign memAddrOut    = fetch_pc_q + ADDR_W'(beat_cnt_q) * ADDR_W'(BEAT_BYTES);
    assign instrValidOut = (count != '0);
    assign instrOut      = head_entry.instr;
    assign instrPcOut    = head_entry.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - directed self-checking bench for fetch_prefetch in three configurations
module tb_fetch_prefetch;

    logic        clk = 1'b0;
    logic        rstN;
    logic        redirectIn;
    logic [31:0] pcIn;
    logic        memReadyIn;
    logic        instrReadyIn;

    logic        req_a, val_a, req_w, val_w, req_h, val_h;
    logic [31:0] addr_a, ins_a, ipc_a;
    logic [31:0] addr_w, ins_w, ipc_w;
    logic [31:0] addr_h, ins_h, ipc_h;
    logic [7:0]  data_a, data_w;
    logic [15:0] data_h;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] hold;

    always #5 clk = ~clk;

    // Memory returns byte = addr[7:0]
    assign data_a = addr_a[7:0];
    assign data_w = addr_w[7:0];
    assign data_h = {addr_h[7:0] + 8'd1, addr_h[7:0]};

    fetch_prefetch dut_a (
        .clk(clk), .rstN(rstN), .redirectIn(redirectIn), .pcIn(pcIn),
        .memReqOut(req_a), .memAddrOut(addr_a), .memReadyIn(memReadyIn), .memDataIn(data_a),
        .instrValidOut(val_a), .instrOut(ins_a), .instrPcOut(ipc_a), .instrReadyIn(instrReadyIn)
    );

    fetch_prefetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rstN(rstN), .redirectIn(redirectIn), .pcIn(pcIn),
        .memReqOut(req_w), .memAddrOut(addr_w), .memReadyIn(memReadyIn), .memDataIn(data_w),
        .instrValidOut(val_w), .instrOut(ins_w), .instrPcOut(ipc_w), .instrReadyIn(instrReadyIn)
    );

    fetch_prefetch #(.BUS_W(16), .DEPTH(4)) dut_h (
        .clk(clk), .rstN(rstN), .redirectIn(redirectIn), .pcIn(pcIn),
        .memReqOut(req_h), .memAddrOut(addr_h), .memReadyIn(memReadyIn), .memDataIn(data_h),
        .instrValidOut(val_h), .instrOut(ins_h), .instrPcOut(ipc_h), .instrReadyIn(instrReadyIn)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirectIn = 1'b1;
        pcIn       = pc;
        tick();
        redirectIn = 1'b0;
    endtask

    initial begin
        rstN = 1'b0; redirectIn = 1'b0; pcIn = '0; memReadyIn = 1'b1; instrReadyIn = 1'b1;
        tick(); tick();
        check("rst_val",   val_a,  1'b0);
        check("rst_req",   req_a,  1'b0);
        check("rst_addr",  addr_a, 32'h0);
        check("rst_instr", ins_a,  32'h0);
        check("rst_pc",    ipc_a,  32'h0);
        check("rst_addr_w", addr_w, 32'hFFFF_FFFC);

        // Reset release: latency, wrap and 16-bit beats
        rstN = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("lat_val_%0d", i), val_a, (i == 5 || i == 9));
            if (i == 1) check("h_addr0", addr_h, 32'h0);
            if (i == 2) check("h_addr1", addr_h, 32'h2);
            if (i == 3) begin
                check("h_val", val_h, 1'b1);
                check("h_instr0", ins_h, 32'h0302_0100);
                check("h_pc0", ipc_h, 32'h0);
            end
            if (i == 4) check("w_addr_ff", addr_w, 32'hFFFF_FFFF);
            if (i == 5) begin
                check("first_instr", ins_a, 32'h0302_0100);
                check("first_pc", ipc_a, 32'h0);
                check("w_addr_wrap", addr_w, 32'h0);
                check("w_instr0", ins_w, 32'hFFFE_FDFC);
                check("w_pc0", ipc_w, 32'hFFFF_FFFC);
                check("h_instr1", ins_h, 32'h0706_0504);
                check("h_pc1", ipc_h, 32'h4);
            end
        end
        check("second_instr", ins_a, 32'h0706_0504);
        check("second_pc", ipc_a, 32'h4);
        check("w_instr1", ins_w, 32'h0302_0100);
        check("w_pc1", ipc_w, 32'h0);

        // Backpressure fills the two-entry buffer
        instrReadyIn = 1'b0;
        redirect_to(32'h0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("redir_lat_%0d", i), val_a, (i == 4));
        end
        for (int i = 0; i < 6; i++) tick();
        check("full_req", req_a, 1'b0);
        check("full_val", val_a, 1'b1);
        check("full_pc", ipc_a, 32'h0);
        check("full_instr", ins_a, 32'h0302_0100);
        check("full_addr", addr_a, 32'h8);
        instrReadyIn = 1'b1;
        tick();
        instrReadyIn = 1'b0;
        check("resume_req", req_a, 1'b1);
        check("resume_addr", addr_a, 32'h8);
        check("pop_pc4", ipc_a, 32'h4);
        check("pop_instr4", ins_a, 32'h0706_0504);
        for (int i = 0; i < 4; i++) tick();
        check("refull_req", req_a, 1'b0);
        instrReadyIn = 1'b1;
        tick();
        instrReadyIn = 1'b0;
        check("pop_pc8", ipc_a, 32'h8);
        check("pop_instr8", ins_a, 32'h0B0A_0908);

        // Memory stalls: address held between accepts
        instrReadyIn = 1'b1;
        memReadyIn   = 1'b0;
        redirect_to(32'h0);
        for (int i = 0; i < 12; i++) begin
            memReadyIn = ((i % 3) == 2);
            hold = addr_a;
            tick();
            if (!memReadyIn) check($sformatf("stall_addr_%0d", i), addr_a, hold);
        end
        check("stall_val", val_a, 1'b1);
        check("stall_instr", ins_a, 32'h0302_0100);
        memReadyIn = 1'b1;

        // Redirect during beat 2 with two entries buffered
        instrReadyIn = 1'b0;
        redirect_to(32'h0);
        for (int i = 0; i < 10; i++) tick();
        check("pre_redir_addr_w", addr_w, 32'hA);
        check("pre_redir_val_w", val_w, 1'b1);
        check("pre_redir_pc_w", ipc_w, 32'h0);
        instrReadyIn = 1'b1;
        redirect_to(32'h100);
        instrReadyIn = 1'b0;
        check("redir_val_w", val_w, 1'b0);
        check("redir_addr_w", addr_w, 32'h100);
        check("redir_req_w", req_w, 1'b1);
        check("redir_addr_a", addr_a, 32'h100);
        check("redir_req_a", req_a, 1'b1);
        check("redir_val_a", val_a, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("redir_w_val_%0d", i), val_w, (i == 4));
        end
        check("redir_pc_w", ipc_w, 32'h100);
        check("redir_instr_w", ins_w, 32'h0302_0100);

        // Asynchronous reset mid-beat on the 16-bit configuration
        tick();
        check("mid_req_h", req_h, 1'b1);
        check("mid_val_h", val_h, 1'b1);
        check("mid_addr_h", addr_h, 32'h10A);
        rstN = 1'b0;
        #1;
        check("areset_req_h", req_h, 1'b0);
        check("areset_val_h", val_h, 1'b0);
        check("areset_instr_h", ins_h, 32'h0);
        check("areset_addr_h", addr_h, 32'h0);
        rstN = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("restart_val_h_%0d", i), val_h, (i == 3));
            if (i == 1) check("restart_addr0_h", addr_h, 32'h0);
            if (i == 2) check("restart_addr1_h", addr_h, 32'h2);
        end
        check("restart_pc_h", ipc_h, 32'h0);
        check("restart_instr_h", ins_h, 32'h0302_0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
